// File: rtl/gate_sweep_controller_if.sv
// rtl/gate_sweep_controller_if.sv - sweep controller <-> gate/host signal bundle
interface gate_sweep_controller_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_cnt;
    logic [N_IN-1:0] first_fail_vec;

    modport master (
        input  start, dut_out,
        output dut_in, busy, done, pass, fail_cnt, first_fail_vec
    );

    modport slave (
        output start, dut_out,
        input  dut_in, busy, done, pass, fail_cnt, first_fail_vec
    );
endinterface

// File: rtl/gate_sweep_controller.sv
// rtl/gate_sweep_controller.sv - exhaustive truth-table sweep of an N-input gate
// Optional GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module gate_sweep_controller #(
    parameter int                N_IN   = 2,
    parameter int                SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXPECT = 4'b1000
) (
    input  logic                   clk,
    input  logic                   rst,
    gate_sweep_controller_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

    localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN:0]   ONE         = (N_IN+1)'(1);
    localparam logic [N_IN:0]   LAST_VEC    = (N_IN+1)'((1 << N_IN) - 1);

    state_t          state_q, state_d;
    logic [N_IN:0]   vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
    logic [N_IN-1:0] ffv_q, ffv_d;
    logic            mismatch;
    logic            sweep_end;

    assign mismatch = (bus.dut_out != EXPECT[vec_q[N_IN-1:0]]);

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        dut_in_d   = dut_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_cnt_d = fail_cnt_q;
        ffv_d      = ffv_q;
        sweep_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                dut_in_d = '0;
                if (bus.start) begin
                    state_d    = S_APPLY;
                    vec_d      = '0;
                    fail_cnt_d = '0;
                    ffv_d      = '0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_APPLY: begin
                dut_in_d = vec_q[N_IN-1:0];
                cnt_d    = SETTLE_LOAD;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    fail_cnt_d = fail_cnt_q + ONE;
                    if (fail_cnt_q == '0) begin
                        ffv_d = vec_q[N_IN-1:0];
                    end
                end
                sweep_end = (vec_q == LAST_VEC);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                sweep_end = sweep_end || mismatch;
`endif
                // pass reflects this cycle's increment so DONE reports the final verdict
                if (sweep_end) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (fail_cnt_d == '0);
                end else begin
                    vec_d   = vec_q + ONE;
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                dut_in_d = '0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            dut_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
            ffv_q      <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            dut_in_q   <= dut_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_cnt_q <= fail_cnt_d;
            ffv_q      <= ffv_d;
        end
    end

    assign bus.dut_in         = dut_in_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.fail_cnt       = fail_cnt_q;
    assign bus.first_fail_vec = ffv_q;
endmodule

// File: tb/tb_gate_sweep_controller.sv
// tb/tb_gate_sweep_controller.sv - randomized sweeps of two controllers against a truth-table model
module tb_gate_sweep_controller;
    localparam int         NV    = 4;
    localparam int         PER   = 4;
    localparam logic [3:0] EXP_A = 4'b1000;
    localparam logic [3:0] EXP_B = 4'b0110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] tt_a = 4'b1000;
    logic [3:0] tt_b = 4'b0110;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    gate_sweep_controller_if #(.N_IN(2)) ifa ();
    gate_sweep_controller_if #(.N_IN(2)) ifb ();

    assign ifa.start   = start;
    assign ifb.start   = start;
    assign ifa.dut_out = tt_a[ifa.dut_in];
    assign ifb.dut_out = tt_b[ifb.dut_in];

    gate_sweep_controller #(.N_IN(2), .SETTLE(2), .EXPECT(EXP_A)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    gate_sweep_controller #(.N_IN(2), .SETTLE(2), .EXPECT(EXP_B)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the truth table, list mismatching vectors, derive the DONE edge.
    task automatic model(input logic [3:0] tt, input logic [3:0] exp,
                         output int cnt, output int first, output int de);
        cnt   = 0;
        first = 0;
        for (int v = 0; v < NV; v++) begin
            if (tt[v] != exp[v]) begin
                if (cnt == 0) first = v;
                cnt++;
            end
        end
        de = NV * PER;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        if (cnt > 0) begin
            cnt = 1;
            de  = (first + 1) * PER;
        end
`endif
    endtask

    task automatic sweep(input logic [3:0] ta, input logic [3:0] tb_v, input bit repulse);
        int cnt[2];
        int first[2];
        int de[2];
        int o_in, o_done, o_busy, o_pass, o_cnt, o_ffv;
        model(ta, EXP_A, cnt[0], first[0], de[0]);
        model(tb_v, EXP_B, cnt[1], first[1], de[1]);
        tt_a = ta;
        tt_b = tb_v;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                o_in   = (i == 0) ? int'(ifa.dut_in) : int'(ifb.dut_in);
                o_done = (i == 0) ? int'(ifa.done) : int'(ifb.done);
                o_busy = (i == 0) ? int'(ifa.busy) : int'(ifb.busy);
                o_pass = (i == 0) ? int'(ifa.pass) : int'(ifb.pass);
                o_cnt  = (i == 0) ? int'(ifa.fail_cnt) : int'(ifb.fail_cnt);
                o_ffv  = (i == 0) ? int'(ifa.first_fail_vec) : int'(ifb.first_fail_vec);
                check($sformatf("dut_in%0d_k%0d", i, k), o_in, (k <= de[i]) ? (k - 1) / PER : 0);
                check($sformatf("done%0d_k%0d", i, k), o_done, (k == de[i]) ? 1 : 0);
                check($sformatf("busy%0d_k%0d", i, k), o_busy, (k <= de[i]) ? 1 : 0);
                if (k == de[i] || k == 20) begin
                    check($sformatf("pass%0d_k%0d", i, k), o_pass, (cnt[i] == 0) ? 1 : 0);
                    check($sformatf("fail_cnt%0d_k%0d", i, k), o_cnt, cnt[i]);
                    if (cnt[i] != 0)
                        check($sformatf("first_fail%0d_k%0d", i, k), o_ffv, first[i]);
                end
            end
            if (repulse) begin
                if (k == 4 || k == 15) start = 1'b1;
                if (k == 5 || k == 16) start = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dut_in", int'(ifa.dut_in), 0);
        check("rst_busy", int'(ifa.busy), 0);
        check("rst_done", int'(ifa.done), 0);
        check("rst_pass", int'(ifa.pass), 0);
        check("rst_fail_cnt", int'(ifa.fail_cnt), 0);
        check("rst_ffv", int'(ifa.first_fail_vec), 0);
        @(negedge clk);
        rst = 1'b0;

        sweep(4'b1000, 4'b0110, 1'b0);
        sweep(4'b0000, 4'b0110, 1'b0);
        sweep(4'b1110, 4'b0110, 1'b0);
        sweep(4'b1000, 4'b0110, 1'b1);

        // Abort mid-sweep with asynchronous reset between edges.
        tt_a = 4'b1111;
        tt_b = 4'b1001;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_busy_a", int'(ifa.busy), 0);
        check("mid_rst_dut_in_a", int'(ifa.dut_in), 0);
        check("mid_rst_fail_cnt_a", int'(ifa.fail_cnt), 0);
        check("mid_rst_pass_a", int'(ifa.pass), 0);
        check("mid_rst_busy_b", int'(ifb.busy), 0);
        check("mid_rst_fail_cnt_b", int'(ifb.fail_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        sweep(4'b1000, 4'b0110, 1'b0);
        sweep(4'b1000, 4'b0110, 1'b0);
        for (int r = 0; r < 8; r++)
            sweep(4'($urandom), 4'($urandom), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
